// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flow controller: FSM encodings,
// default parameters, forwarding selects and the control-bundle layout.
package pipeline_ctrl_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned REG_AW          = 5;
  localparam int unsigned DRAIN_W         = 2;
  localparam int unsigned DRAIN_LEN       = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  // Operand forwarding selects used by the datapath bypass muxes
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EX_ME = 2'd1,
    FWD_ME_WB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_me_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic me_wb_bubble;
    logic pc_redirect_en;
  } ctrl_t;

  // A source read collides with a pending write; x0 never collides
  function automatic logic src_hit(logic [REG_AW-1:0] rd,
                                   logic [REG_AW-1:0] rs,
                                   logic              use_rs);
    return use_rs && (rd == rs) && (rd != '0);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stall/flush controls and
// performance counters out.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = pipeline_ctrl_pkg::CNT_W_DEF
) ();

  logic [pipeline_ctrl_pkg::REG_AW-1:0] id_rs1;
  logic [pipeline_ctrl_pkg::REG_AW-1:0] id_rs2;
  logic                                 id_use_rs1;
  logic                                 id_use_rs2;
  logic [pipeline_ctrl_pkg::REG_AW-1:0] ex_rd;
  logic                                 ex_mem_read;
  logic                                 ex_branch_taken;
  logic                                 me_mem_req;
  logic                                 dmem_ready;
  logic                                 halt_req;
  logic                                 resume;
  logic                                 cnt_clr;

  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             ex_me_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             me_wb_bubble;
  logic             pc_redirect_en;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, me_mem_req, dmem_ready, halt_req, resume, cnt_clr,
    input  pc_stall, if_id_stall, id_ex_stall, ex_me_stall, if_id_flush,
           id_ex_flush, me_wb_bubble, pc_redirect_en, halted, mem_err,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, me_mem_req, dmem_ready, halt_req, resume, cnt_clr,
    output pc_stall, if_id_stall, id_ex_stall, ex_me_stall, if_id_flush,
           id_ex_flush, me_wb_bubble, pc_redirect_en, halted, mem_err,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait freezing with timeout, debug halt drain, and performance counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = pipeline_ctrl_pkg::MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = pipeline_ctrl_pkg::CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  pipeline_ctrl_if.slave bus
);

  import pipeline_ctrl_pkg::*;

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic               ret_drain_q, ret_drain_d;
  logic               halt_pend_q, halt_pend_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               mem_err_q, mem_err_d;

  ctrl_t              ctrl_c;
  logic               stall_inc_c;
  logic               flush_inc_c;
  logic               load_use_c;
  logic               mem_hold_c;
  logic               in_wait_c;
  logic               drain_like_c;
  logic               halt_now_c;
  logic [WAIT_W-1:0]  wait_n_c;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  assign load_use_c = bus.ex_mem_read &&
                      (src_hit(bus.ex_rd, bus.id_rs1, bus.id_use_rs1) ||
                       src_hit(bus.ex_rd, bus.id_rs2, bus.id_use_rs2));
  assign mem_hold_c = bus.me_mem_req && !bus.dmem_ready;
  assign in_wait_c  = (state_q == ST_MEM_WAIT);

  // MEM_WAIT behaves as the state it froze once memory completes
  assign drain_like_c = (state_q == ST_DRAIN) || (in_wait_c && ret_drain_q);
  assign halt_now_c   = ((state_q == ST_RUN) && bus.halt_req) ||
                        (in_wait_c && !ret_drain_q && (halt_pend_q || bus.halt_req));
  assign wait_n_c     = (in_wait_c ? wait_q : WAIT_W'(0)) + WAIT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      ret_drain_q <= 1'b0;
      halt_pend_q <= 1'b0;
      wait_q      <= '0;
      drain_q     <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      halt_pend_q <= halt_pend_d;
      wait_q      <= wait_d;
      drain_q     <= drain_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_drain_d = ret_drain_q;
    halt_pend_d = halt_pend_q;
    wait_d      = wait_q;
    drain_d     = drain_q;
    mem_err_d   = mem_err_q;
    ctrl_c      = '0;
    stall_inc_c = 1'b0;
    flush_inc_c = 1'b0;

    if (state_q == ST_HALTED) begin
      ctrl_c.pc_stall    = 1'b1;
      ctrl_c.if_id_stall = 1'b1;
      ctrl_c.id_ex_stall = 1'b1;
      ctrl_c.ex_me_stall = 1'b1;
      if (bus.resume) begin
        state_d   = ST_RUN;
        mem_err_d = 1'b0;
      end
    end else if (mem_hold_c) begin
      // Freeze the whole pipe; a pending branch waits for the completing cycle
      ctrl_c.pc_stall     = 1'b1;
      ctrl_c.if_id_stall  = 1'b1;
      ctrl_c.id_ex_stall  = 1'b1;
      ctrl_c.ex_me_stall  = 1'b1;
      ctrl_c.me_wb_bubble = 1'b1;
      ctrl_c.if_id_flush  = drain_like_c;
      stall_inc_c         = 1'b1;
      if (wait_n_c >= WAIT_W'(MEM_TIMEOUT)) begin
        state_d     = ST_HALTED;
        mem_err_d   = 1'b1;
        wait_d      = '0;
        halt_pend_d = 1'b0;
        ret_drain_d = 1'b0;
        drain_d     = '0;
      end else begin
        state_d     = ST_MEM_WAIT;
        wait_d      = wait_n_c;
        halt_pend_d = halt_now_c;
        if (!in_wait_c) begin
          ret_drain_d = drain_like_c;
        end
      end
    end else begin
      wait_d      = '0;
      halt_pend_d = 1'b0;
      ret_drain_d = 1'b0;
      if (bus.ex_branch_taken) begin
        ctrl_c.if_id_flush    = 1'b1;
        ctrl_c.id_ex_flush    = 1'b1;
        ctrl_c.pc_redirect_en = 1'b1;
        flush_inc_c           = 1'b1;
      end else if (load_use_c) begin
        ctrl_c.pc_stall    = 1'b1;
        ctrl_c.if_id_stall = 1'b1;
        ctrl_c.id_ex_flush = 1'b1;
        stall_inc_c        = 1'b1;
      end
      if (drain_like_c) begin
        ctrl_c.pc_stall    = 1'b1;
        ctrl_c.if_id_flush = 1'b1;
        if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_DRAIN;
          drain_d = drain_q - DRAIN_W'(1);
        end
      end else if (halt_now_c) begin
        state_d = ST_DRAIN;
        drain_d = DRAIN_W'(DRAIN_LEN - 1);
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (stall_inc_c),
    .clr   (bus.cnt_clr),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (flush_inc_c),
    .clr   (bus.cnt_clr),
    .count (flush_cnt)
  );

  assign bus.pc_stall       = ctrl_c.pc_stall;
  assign bus.if_id_stall    = ctrl_c.if_id_stall;
  assign bus.id_ex_stall    = ctrl_c.id_ex_stall;
  assign bus.ex_me_stall    = ctrl_c.ex_me_stall;
  assign bus.if_id_flush    = ctrl_c.if_id_flush;
  assign bus.id_ex_flush    = ctrl_c.id_ex_flush;
  assign bus.me_wb_bubble   = ctrl_c.me_wb_bubble;
  assign bus.pc_redirect_en = ctrl_c.pc_redirect_en;
  assign bus.halted         = (state_q == ST_HALTED);
  assign bus.mem_err        = mem_err_q;
  assign bus.stall_cycles   = stall_cnt;
  assign bus.flush_count    = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: single-cycle vector table plus hand-written
// sequences for memory wait, drain, timeout, saturation and reset.
module tb_pipeline_ctrl;

  localparam int unsigned CNT_W = 4;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_0100;
  localparam logic [7:0] C_BR   = 8'b0000_1101;
  localparam logic [7:0] C_FRZ  = 8'b1111_0010;
  localparam logic [7:0] C_FRZD = 8'b1111_1010;
  localparam logic [7:0] C_HALT = 8'b1111_0000;
  localparam logic [7:0] C_DRN  = 8'b1000_1000;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mrd;
    logic       br;
    logic       mreq;
    logic       rdy;
    logic       hreq;
    logic       res;
    logic       clr;
  } stim_t;

  typedef struct {
    string      name;
    logic [7:0] ctrl;
    logic       halted;
    logic       mem_err;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic clk;
  logic rstn;
  int   errors;
  int   checks;
  exp_t sb_q[$];
  vec_t tbl[13];

  stim_t s_idle, s_lu, s_hold, s_hold_hreq, s_rdy, s_rdy_br, s_hold_br;
  stim_t s_hreq, s_res, s_clr, s_lu_clr;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                               logic [4:0] rd, logic mrd, logic br, logic mreq,
                               logic rdy, logic hreq, logic res, logic clr);
    stim_t s;
    s = '{rs1, rs2, u1, u2, rd, mrd, br, mreq, rdy, hreq, res, clr};
    return s;
  endfunction

  function automatic exp_t ex(string n, logic [7:0] c, logic h, logic e,
                              logic [3:0] sc, logic [3:0] fc);
    exp_t r;
    r.name    = n;
    r.ctrl    = c;
    r.halted  = h;
    r.mem_err = e;
    r.sc      = sc;
    r.fc      = fc;
    return r;
  endfunction

  task automatic drive(input stim_t s);
    bus.id_rs1          = s.rs1;
    bus.id_rs2          = s.rs2;
    bus.id_use_rs1      = s.u1;
    bus.id_use_rs2      = s.u2;
    bus.ex_rd           = s.rd;
    bus.ex_mem_read     = s.mrd;
    bus.ex_branch_taken = s.br;
    bus.me_mem_req      = s.mreq;
    bus.dmem_ready      = s.rdy;
    bus.halt_req        = s.hreq;
    bus.resume          = s.res;
    bus.cnt_clr         = s.clr;
  endtask

  task automatic check_one();
    exp_t        e;
    logic [17:0] act;
    logic [17:0] req;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e   = sb_q.pop_front();
    act = {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_me_stall,
           bus.if_id_flush, bus.id_ex_flush, bus.me_wb_bubble, bus.pc_redirect_en,
           bus.halted, bus.mem_err, bus.stall_cycles, bus.flush_count};
    req = {e.ctrl, e.halted, e.mem_err, e.sc, e.fc};
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got ctrl=%b halted=%b mem_err=%b stall=%0d flush=%0d, want ctrl=%b halted=%b mem_err=%b stall=%0d flush=%0d",
               e.name, act[17:10], act[9], act[8], act[7:4], act[3:0],
               req[17:10], req[9], req[8], req[7:4], req[3:0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check mid-cycle
  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    drive(s);
    sb_q.push_back(e);
    @(negedge clk);
    check_one();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;

    s_idle      = '0;
    s_lu        = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    s_hold      = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    s_hold_br   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    s_hold_hreq = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    s_rdy       = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    s_rdy_br    = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    s_hreq      = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    s_res       = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    s_clr       = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    s_lu_clr    = s_lu;
    s_lu_clr.clr = 1'b1;

    tbl[0]  = '{s_idle, ex("t_idle",        C_NONE, 0, 0, 0, 0)};
    tbl[1]  = '{s_lu,   ex("t_lu_rs2",      C_LU,   0, 0, 0, 0)};
    tbl[2]  = '{s_idle, ex("t_lu_one_bub",  C_NONE, 0, 0, 1, 0)};
    tbl[3]  = '{mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                ex("t_lu_rs1",      C_LU,   0, 0, 1, 0)};
    tbl[4]  = '{mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                ex("t_x0_no_haz",   C_NONE, 0, 0, 2, 0)};
    tbl[5]  = '{mk(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                ex("t_unused_src",  C_NONE, 0, 0, 2, 0)};
    tbl[6]  = '{mk(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                ex("t_not_load",    C_NONE, 0, 0, 2, 0)};
    tbl[7]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                ex("t_branch",      C_BR,   0, 0, 2, 0)};
    tbl[8]  = '{mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                ex("t_br_over_lu",  C_BR,   0, 0, 2, 1)};
    tbl[9]  = '{s_rdy,  ex("t_mem_ready",   C_NONE, 0, 0, 2, 2)};
    tbl[10] = '{s_idle, ex("t_idle2",       C_NONE, 0, 0, 2, 2)};
    tbl[11] = '{s_clr,  ex("t_clr",         C_NONE, 0, 0, 2, 2)};
    tbl[12] = '{s_idle, ex("t_cleared",     C_NONE, 0, 0, 0, 0)};

    rstn = 1'b0;
    drive(s_idle);
    #2;
    sb_q.push_back(ex("reset_state", C_NONE, 0, 0, 0, 0));
    check_one();
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) step(tbl[i].s, tbl[i].e);

    // Branch held behind a 3-cycle memory wait
    step(s_hold_br, ex("bw_frz1",  C_FRZ,  0, 0, 0, 0));
    step(s_hold_br, ex("bw_frz2",  C_FRZ,  0, 0, 1, 0));
    step(s_hold_br, ex("bw_frz3",  C_FRZ,  0, 0, 2, 0));
    step(s_rdy_br,  ex("bw_flush", C_BR,   0, 0, 3, 0));
    step(s_idle,    ex("bw_after", C_NONE, 0, 0, 3, 1));
    step(s_clr,     ex("bw_clr",   C_NONE, 0, 0, 3, 1));
    step(s_idle,    ex("bw_zero",  C_NONE, 0, 0, 0, 0));

    // Plain halt drain, ignored halt_req/resume
    step(s_hreq, ex("dr_req", C_NONE, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) step(s_idle, ex("dr_drain", C_DRN, 0, 0, 0, 0));
    step(s_idle, ex("dr_halted",    C_HALT, 1, 0, 0, 0));
    step(s_hreq, ex("dr_hreq_ign",  C_HALT, 1, 0, 0, 0));
    step(s_res,  ex("dr_resume",    C_HALT, 1, 0, 0, 0));
    step(s_idle, ex("dr_run",       C_NONE, 0, 0, 0, 0));
    step(s_res,  ex("dr_res_ign",   C_NONE, 0, 0, 0, 0));
    step(s_idle, ex("dr_still_run", C_NONE, 0, 0, 0, 0));

    // Drain with a 2-cycle memory hold: six drain-side cycles before halt
    step(s_hreq, ex("dh_req",   C_NONE, 0, 0, 0, 0));
    step(s_idle, ex("dh_d1",    C_DRN,  0, 0, 0, 0));
    step(s_hold, ex("dh_frz1",  C_FRZD, 0, 0, 0, 0));
    step(s_hold, ex("dh_frz2",  C_FRZD, 0, 0, 1, 0));
    step(s_rdy,  ex("dh_d2",    C_DRN,  0, 0, 2, 0));
    step(s_idle, ex("dh_d3",    C_DRN,  0, 0, 2, 0));
    step(s_idle, ex("dh_d4",    C_DRN,  0, 0, 2, 0));
    step(s_idle, ex("dh_halt",  C_HALT, 1, 0, 2, 0));
    step(s_res,  ex("dh_res",   C_HALT, 1, 0, 2, 0));
    step(s_idle, ex("dh_run",   C_NONE, 0, 0, 2, 0));
    step(s_clr,  ex("dh_clr",   C_NONE, 0, 0, 2, 0));

    // halt_req during a memory wait is honoured when the wait ends
    step(s_hold,      ex("hp_frz1",  C_FRZ,  0, 0, 0, 0));
    step(s_hold_hreq, ex("hp_frz2",  C_FRZ,  0, 0, 1, 0));
    step(s_rdy,       ex("hp_exit",  C_NONE, 0, 0, 2, 0));
    for (int i = 0; i < 4; i++) step(s_idle, ex("hp_drain", C_DRN, 0, 0, 2, 0));
    step(s_idle, ex("hp_halt", C_HALT, 1, 0, 2, 0));
    step(s_res,  ex("hp_res",  C_HALT, 1, 0, 2, 0));
    step(s_idle, ex("hp_run",  C_NONE, 0, 0, 2, 0));
    step(s_clr,  ex("hp_clr",  C_NONE, 0, 0, 2, 0));

    // 64 held cycles: timeout, stall counter saturates at 15
    for (int i = 0; i < 64; i++)
      step(s_hold, ex("to_wait", C_FRZ, 0, 0, 4'((i > 15) ? 15 : i), 0));
    step(s_hold,   ex("to_halted",  C_HALT, 1, 1, 15, 0));
    step(s_res,    ex("to_resume",  C_HALT, 1, 1, 15, 0));
    step(s_idle,   ex("to_run",     C_NONE, 0, 0, 15, 0));
    step(s_lu_clr, ex("sat_clr_inc", C_LU,  0, 0, 15, 0));
    step(s_idle,   ex("sat_cleared", C_NONE, 0, 0, 0, 0));

    // Reset asserted in the middle of a memory wait with a pending halt
    step(s_lu,        ex("rw_lu",   C_LU,  0, 0, 0, 0));
    step(s_hold,      ex("rw_frz1", C_FRZ, 0, 0, 1, 0));
    step(s_hold_hreq, ex("rw_frz2", C_FRZ, 0, 0, 2, 0));
    #2;
    drive(s_idle);
    rstn = 1'b0;
    #1;
    sb_q.push_back(ex("rw_in_reset", C_NONE, 0, 0, 0, 0));
    check_one();
    @(negedge clk);
    rstn = 1'b1;
    step(s_idle, ex("rw_run",     C_NONE, 0, 0, 0, 0));
    step(s_rdy,  ex("rw_rdy",     C_NONE, 0, 0, 0, 0));
    step(s_idle, ex("rw_no_pend", C_NONE, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64: the maximum number of consecutive data-memory wait cycles before an error is flagged.
REQ-002 SHALL have parameter CNT_W, default 16: the width of each performance counter.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port id_rs1 / id_rs2, input, 5 bits each: the source registers of the instruction in ID.
REQ-006 SHALL have port id_use_rs1 / id_use_rs2, input, 1 bit each: the ID instruction actually reads that source.
REQ-007 SHALL have port ex_rd, input, 5 bits, and port ex_mem_read, input, 1 bit: the destination register of the EX instruction, and whether it is a load.
REQ-008 SHALL have port ex_branch_taken, input, 1 bit: a branch or jump resolved taken in EX.
REQ-009 SHALL have port me_mem_req, input, 1 bit, and port dmem_ready, input, 1 bit: a MEM-stage access is active, and data memory is completing it this cycle.
REQ-010 SHALL have port halt_req, input, 1 bit, and port resume, input, 1 bit: single-cycle debug pulses.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous clear of all performance counters.
REQ-012 SHALL have outputs pc_stall, if_id_stall, id_ex_stall, ex_me_stall, each 1 bit: hold the PC or that pipeline register.
REQ-013 SHALL have outputs if_id_flush, id_ex_flush, me_wb_bubble, each 1 bit: insert a NOP into that register.
REQ-014 SHALL have output pc_redirect_en, 1 bit: permit the PC to load the branch target.
REQ-015 SHALL have outputs halted, 1 bit, and mem_err, 1 bit (sticky): the core is halted, and a memory timeout has occurred.
REQ-016 SHALL have outputs stall_cycles and flush_count, each CNT_W bits: saturating performance counters.

Function
REQ-017 SHALL implement an FSM with states RUN, MEM_WAIT, DRAIN and HALTED; the state is registered and the control outputs are combinational from the state and the current inputs.
REQ-018 SHALL define load_use = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
REQ-019 SHALL define mem_hold = me_mem_req && !dmem_ready.
REQ-020 SHALL apply these priorities in RUN and DRAIN: mem_hold > ex_branch_taken > load_use.
REQ-021 SHALL, on mem_hold, assert all four stalls plus me_wb_bubble, deassert pc_redirect_en, and enter or stay in MEM_WAIT.
REQ-022 SHALL, on ex_branch_taken without mem_hold, assert if_id_flush, id_ex_flush and pc_redirect_en for exactly that cycle, and increment flush_count.
REQ-023 SHALL, on load_use only, assert pc_stall, if_id_stall and id_ex_flush for one cycle, producing exactly one bubble.
REQ-024 SHALL let a branch held during MEM_WAIT take effect in the first cycle with dmem_ready=1.
REQ-025 SHALL keep a wait counter in MEM_WAIT that increments each held cycle.
REQ-026 SHALL, on the MEM_TIMEOUT-th consecutive held cycle, set mem_err and go to HALTED.
REQ-027 SHALL, in MEM_WAIT, return to the pre-wait state (RUN or DRAIN) when dmem_ready=1, and clear the wait counter.
REQ-028 SHALL, on halt_req in RUN, enter DRAIN; a halt_req arriving in MEM_WAIT SHALL be latched as pending and honoured on exit.
REQ-029 SHALL, in DRAIN, assert pc_stall and if_id_flush continuously and count 4 non-frozen cycles (3 to 0), then enter HALTED; the count SHALL hold while mem_hold is asserted.
REQ-030 SHALL, in HALTED, assert halted and all four stalls and leave pc_redirect_en low; resume SHALL return to RUN and clear mem_err.
REQ-031 SHALL ignore resume in any state other than HALTED, and ignore halt_req in DRAIN or HALTED.
REQ-032 SHALL increment stall_cycles by 1 on each load_use or mem_hold cycle; both counters SHALL saturate at all-ones.
REQ-033 SHALL let cnt_clr take priority over a same-cycle increment.

Reset
REQ-034 SHALL, while rstn=0, asynchronously force state=RUN, the wait counter, drain counter and pending halt to 0, mem_err=0, and both performance counters to 0.
REQ-035 SHALL, after reset, drive all stall, flush and bubble outputs to 0, pc_redirect_en to 0, and halted to 0 while no request is active.
REQ-036 SHALL, on reset asserted mid-MEM_WAIT or mid-DRAIN, abandon the operation with no residual pending state.

Structure
REQ-037 SHALL place the FSM state encodings and the default MEM_TIMEOUT value in the shared define file, beside the forwarding-select macros.
REQ-038 SHALL implement both performance counters as instances of one sub-module, sat_counter (parameter W; inputs inc and clr).

Verification
REQ-039 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_stall=1 and id_ex_flush=1, and stall_cycles=1.
REQ-040 SHALL cover branch during memory wait: mem_hold for 3 cycles with ex_branch_taken=1 -> freeze for 3 cycles, flush on cycle 4, flush_count=1, stall_cycles=3.
REQ-041 SHALL cover timeout: dmem_ready held at 0 for 64 cycles -> mem_err=1 and halted=1; then resume -> RUN with mem_err=0.
REQ-042 SHALL cover halt drain: halt_req in RUN -> 4 DRAIN cycles, then halted=1; with a 2-cycle mem_hold injected mid-drain, halted=1 after 6 cycles.
REQ-043 SHALL cover saturation and clear: CNT_W=4 with 20 stall cycles -> stall_cycles=15; cnt_clr concurrent with an increment -> 0.
REQ-044 SHALL cover reset in MEM_WAIT: rstn pulsed low -> RUN immediately, all outputs 0, counters 0.
